dma_intr_arbiter: RTL
=====================

Name: dma_intr_arbiter

Overview:
- Captures rising edges on the per-channel DMA interrupt lines into a pending register.
- Serialises pending channels to a single service port with a valid/ack handshake, using round-robin arbitration.
- Sits between the DMA engines and the interrupt-servicing logic. Exports a one-hot grant vector so the LED debugger can display which channel is in service.

Parameters:
- N_CH, 8, number of DMA interrupt channels (2..32)
- ID_W, $clog2(N_CH), width of the channel id
- HOLDOFF, 2, idle cycles forced after each ack before the next grant (0 = back-to-back)
- OVR_W, 8, width of the saturating overrun counters (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dma_intr  in  N_CH  raw interrupt lines, one per DMA channel; a rising edge is the event
- intr_mask  in  N_CH  1 = channel masked
- irq_valid  out  1  a grant is presented
- irq_id  out  ID_W  granted channel number
- irq_ack  in  1  consumer accepts the current grant
- grant_onehot  out  N_CH  one-hot form of irq_id, qualified by irq_valid
- pending  out  N_CH  pending register
- busy  out  1  high when the FSM is not in IDLE
- ovr_sel  in  ID_W  overrun counter select (optional feature only)
- ovr_count  out  OVR_W  overrun count of channel ovr_sel (optional feature only)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: irq_valid=0, irq_id=0, grant_onehot=0, pending=0, busy=0, dma_intr_q=0, state=IDLE, rr_last=N_CH-1 (so channel 0 has priority first), holdoff counter=0, overrun counters=0.
- Edge detect: rise = dma_intr & ~dma_intr_q. dma_intr_q is registered every cycle.
  - A line that is high when rst deasserts counts as a rise on the first cycle after reset.
- Capture: pending[i] is set at the edge where rise[i] & ~intr_mask[i].
  - Masked rises are discarded, not deferred.
  - Pending bits of channels that become masked are retained but are not eligible for selection.
- Eligibility: eligible = pending & ~intr_mask.
- Selection: the first eligible channel searching rr_last+1, rr_last+2, ... with wrap-around modulo N_CH.
- FSM states:
  - IDLE: if eligible is non-zero, register irq_id = selection, set irq_valid=1, go to GRANT. Otherwise stay.
  - GRANT: irq_id and irq_valid are held stable until irq_ack=1.
    - On the ack cycle: clear pending[irq_id], set rr_last=irq_id, and drop irq_valid at the next edge.
    - Then go to HOLDOFF if HOLDOFF>0, else to IDLE.
  - HOLDOFF: count HOLDOFF cycles, then go to IDLE.
- Latency:
  - dma_intr high in cycle t -> pending bit visible t+1 -> irq_valid=1 in t+2 when IDLE.
  - Back-to-back grants with HOLDOFF=0: ack in cycle t -> next irq_valid in t+2.
- Simultaneous events:
  - A rise on a channel in the same cycle its pending bit is cleared by ack leaves the bit set (set wins), and it is counted as a new event.
  - Multiple simultaneous rises are all captured.
- Mask change during GRANT does not revoke the current grant.
- irq_ack while irq_valid=0 is ignored.
- A rise on an already-pending channel is merged (not counted twice).
- rst asserted in any state returns all state to reset values at that edge. An in-flight grant is dropped without an ack.

Optional Feature:
- Macro: DMA_INTR_OVERRUN_CNT_EN
- Defined:
  - Per-channel OVR_W-bit counter increments when rise[i] & ~intr_mask[i] & pending[i] and that pending bit is not cleared in that same cycle.
  - Counters saturate at all-ones.
  - ovr_count = counter[ovr_sel], combinational.
  - ovr_sel >= N_CH returns 0.
- Undefined: counters are absent, ovr_sel is ignored, ovr_count is tied to 0. Ports are kept in both builds.

Decomposition:
- Shared package dma_dbg_pkg holds:
  - the FSM state typedef (IDLE, GRANT, HOLDOFF)
  - the N_CH default constant
  - a function for the rotating first-one search
- One sub-module is natural: rr_pick. It is purely combinational: inputs eligible and rr_last; outputs sel_id and sel_valid.

Test Plan:
- Single event: pulse dma_intr[3] for 1 cycle at t0 -> irq_valid=1, irq_id=3 at t0+2. Hold without ack for 5 cycles -> id stable. Ack -> pending[3]=0, busy drops after HOLDOFF+1 cycles.
- Round-robin: rise on channels 0, 2 and 5 together, ack each grant immediately -> grant order 0, 2, 5. Then rise on 0 and 5 -> order 0, 5 (rr_last=5 wraps to 0).
- Mask: intr_mask[1]=1, pulse channel 1 -> pending stays 0. Set pending[4] then mask 4 -> no grant. Unmask -> grant id 4.
- Set-wins collision: grant on channel 6, assert irq_ack in the same cycle as a new rise on 6 -> pending[6] stays 1 and channel 6 is re-granted after holdoff.
- Reset mid-grant: irq_valid=1 on id 2, assert rst for 1 cycle -> irq_valid=0, pending=0, state IDLE next cycle. First grant afterwards starts the search at channel 0.
- Overrun (with DMA_INTR_OVERRUN_CNT_EN): 300 rises on channel 7 with no ack, ovr_sel=7 -> ovr_count=255 (saturated). Without the macro -> ovr_count=0.

Source files
------------

// File: rtl/dma_dbg_pkg.sv
// Shared types, defaults and the rotating first-one search used by the DMA interrupt arbiter.
package dma_dbg_pkg;

  localparam int unsigned NChDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StHoldoff
  } arb_state_e;

  // Returns {found, id}: the first set bit of elig at last+1, last+2, ... (mod n_ch).
  // Covers up to 32 channels; callers zero-extend narrower vectors.
  function automatic logic [5:0] rr_first(input logic [31:0] elig, input logic [4:0] last,
                                          input int unsigned n_ch);
    logic [5:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= n_ch; k++) begin
      idx = (32'(last) + k) % n_ch;
      if (!res[5] && elig[idx]) begin
        res = {1'b1, 5'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_intr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible channel after rr_last_i, with wrap-around.
module dma_intr_arbiter_rr_pick
  import dma_dbg_pkg::*;
#(
  parameter int unsigned N_CH = NChDefault,
  parameter int unsigned ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible_i,
  input  logic [ID_W-1:0] rr_last_i,
  output logic [ID_W-1:0] sel_id_o,
  output logic            sel_valid_o
);

  logic [5:0] res;
  logic       unused_res;

  assign res         = rr_first(32'(eligible_i), 5'(rr_last_i), N_CH);
  assign sel_valid_o = res[5];
  assign sel_id_o    = res[ID_W-1:0];
  assign unused_res  = ^res;

endmodule

// File: rtl/dma_intr_arbiter.sv
// DMA interrupt arbiter: rising-edge capture, round-robin serialisation onto a valid/ack port.
// Define DMA_INTR_OVERRUN_CNT_EN to build the per-channel saturating overrun counters.
module dma_intr_arbiter
  import dma_dbg_pkg::*;
#(
  parameter int unsigned N_CH    = NChDefault,
  parameter int unsigned ID_W    = $clog2(N_CH),
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned OVR_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  dma_intr_i,
  input  logic [N_CH-1:0]  intr_mask_i,
  output logic             irq_valid_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  output logic [N_CH-1:0]  grant_onehot_o,
  output logic [N_CH-1:0]  pending_o,
  output logic             busy_o,
  input  logic [ID_W-1:0]  ovr_sel_i,
  output logic [OVR_W-1:0] ovr_count_o
);

  localparam int unsigned    HCW      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0] HoldLast = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  arb_state_e      state_q, state_d;
  logic [N_CH-1:0] dma_intr_q, pending_q, pending_d;
  logic [N_CH-1:0] rise, capture, clear, eligible;
  logic [ID_W-1:0] irq_id_q, irq_id_d, rr_last_q, rr_last_d, sel_id;
  logic            irq_valid_q, irq_valid_d, sel_valid, ack_fire;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

  assign rise     = dma_intr_i & ~dma_intr_q;
  assign capture  = rise & ~intr_mask_i;
  assign eligible = pending_q & ~intr_mask_i;
  assign ack_fire = (state_q == StGrant) && irq_ack_i;

  always_comb begin
    clear = '0;
    for (int i = 0; i < N_CH; i++) begin
      clear[i] = ack_fire && (irq_id_q == ID_W'(i));
    end
  end

  // A fresh rise on the channel being acked keeps its pending bit set.
  assign pending_d = (pending_q & ~clear) | capture;

  dma_intr_arbiter_rr_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_rr_pick (
    .eligible_i  (eligible),
    .rr_last_i   (rr_last_q),
    .sel_id_o    (sel_id),
    .sel_valid_o (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    irq_valid_d = irq_valid_q;
    rr_last_d   = rr_last_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          irq_id_d    = sel_id;
          irq_valid_d = 1'b1;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (irq_ack_i) begin
          irq_valid_d = 1'b0;
          rr_last_d   = irq_id_q;
          hold_cnt_d  = '0;
          state_d     = (HOLDOFF > 0) ? StHoldoff : StIdle;
        end
      end
      StHoldoff: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      dma_intr_q  <= '0;
      pending_q   <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
      rr_last_q   <= ID_W'(N_CH - 1);
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dma_intr_q  <= dma_intr_i;
      pending_q   <= pending_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
      rr_last_q   <= rr_last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  always_comb begin
    grant_onehot_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant_onehot_o[i] = irq_valid_q && (irq_id_q == ID_W'(i));
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign pending_o   = pending_q;
  assign busy_o      = (state_q != StIdle);

`ifdef DMA_INTR_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q [N_CH];

  // Only a rise that merges into a pending bit surviving this cycle is an overrun.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst_i) begin
        ovr_q[i] <= '0;
      end else if (capture[i] && pending_q[i] && !clear[i] && (ovr_q[i] != '1)) begin
        ovr_q[i] <= ovr_q[i] + 1'b1;
      end
    end
  end

  assign ovr_count_o = (32'(ovr_sel_i) < N_CH) ? ovr_q[ovr_sel_i] : '0;
`else
  logic unused_ovr_sel;
  assign unused_ovr_sel = ^ovr_sel_i;
  assign ovr_count_o    = '0;
`endif

endmodule
